// File: rtl/calc1_pkg.sv
// Shared command/response encodings and port FSM states for the calc1 golden model.
package calc1_pkg;

  localparam int NPORTS = 4;
  localparam int DW     = 32;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_LSH = 4'd5;
  localparam logic [0:3] CMD_RSH = 4'd6;

  localparam logic [0:1] RSP_NONE = 2'd0;
  localparam logic [0:1] RSP_SUCC = 2'd1;
  localparam logic [0:1] RSP_INOF = 2'd2;
  localparam logic [0:1] RSP_IERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_RESP
  } port_state_t;

endpackage

// File: rtl/calc1_port.sv
// One calc1 request port: command/operand FSM, ALU and registered one-cycle response.
module calc1_port
  import calc1_pkg::*;
(
  input  logic          c_clk,
  input  logic          reset,
  input  logic [0:3]    cmd_in,
  input  logic [0:DW-1] data_in,
  output logic [0:DW-1] out_data,
  output logic [0:1]    out_resp
);

  port_state_t   state, next_state;
  logic [0:3]    cmd_q;
  logic [0:DW-1] op1_q, op2_q;
  logic          accept;
  logic [0:DW]   sum;
  logic [0:4]    shamt;
  logic [0:1]    alu_resp;
  logic [0:DW-1] alu_data;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // RESP doubles as an IDLE for sampling, which gives the 2-cycle command pitch
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = (cmd_in != CMD_NOP);
        if (accept) next_state = ST_OP2;
      end
      ST_OP2:  next_state = ST_RESP;
      ST_RESP: begin
        accept     = (cmd_in != CMD_NOP);
        next_state = accept ? ST_OP2 : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q <= CMD_NOP;
      op1_q <= '0;
      op2_q <= '0;
    end else begin
      if (accept) begin
        cmd_q <= cmd_in;
        op1_q <= data_in;
      end
      if (state == ST_OP2) op2_q <= data_in;
    end
  end

  // Bit 0 is the MSB, so sum[0] is the carry out of the 32-bit add
  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, op2_q};
    shamt    = op2_q[DW-5:DW-1];
    alu_resp = RSP_INOF;
    alu_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum[0]) begin
          alu_resp = RSP_SUCC;
          alu_data = sum[1:DW];
        end
      end
      CMD_SUB: begin
        if (op2_q <= op1_q) begin
          alu_resp = RSP_SUCC;
          alu_data = op1_q - op2_q;
        end
      end
      CMD_LSH: begin
        alu_resp = RSP_SUCC;
        alu_data = op1_q << shamt;
      end
      CMD_RSH: begin
        alu_resp = RSP_SUCC;
        alu_data = op1_q >> shamt;
      end
      default: begin
        alu_resp = RSP_INOF;
        alu_data = '0;
      end
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      out_resp <= RSP_NONE;
      out_data <= '0;
    end else if (state == ST_RESP) begin
      out_resp <= alu_resp;
      out_data <= (alu_resp == RSP_SUCC) ? alu_data : '0;
    end else begin
      out_resp <= RSP_NONE;
      out_data <= '0;
    end
  end

endmodule

// File: rtl/calc1_reference_model.sv
// calc1 four-port golden model: four independent calc1_port instances, no shared logic.
module calc1_reference_model
  import calc1_pkg::*;
(
  input  logic          c_clk,
  input  logic          reset,
  input  logic [0:3]    req1_cmd_in,
  input  logic [0:DW-1] req1_data_in,
  input  logic [0:3]    req2_cmd_in,
  input  logic [0:DW-1] req2_data_in,
  input  logic [0:3]    req3_cmd_in,
  input  logic [0:DW-1] req3_data_in,
  input  logic [0:3]    req4_cmd_in,
  input  logic [0:DW-1] req4_data_in,
  output logic [0:DW-1] out_data1,
  output logic [0:1]    out_resp1,
  output logic [0:DW-1] out_data2,
  output logic [0:1]    out_resp2,
  output logic [0:DW-1] out_data3,
  output logic [0:1]    out_resp3,
  output logic [0:DW-1] out_data4,
  output logic [0:1]    out_resp4
);

  calc1_port u_port1 (
    .c_clk    (c_clk),
    .reset    (reset),
    .cmd_in   (req1_cmd_in),
    .data_in  (req1_data_in),
    .out_data (out_data1),
    .out_resp (out_resp1)
  );

  calc1_port u_port2 (
    .c_clk    (c_clk),
    .reset    (reset),
    .cmd_in   (req2_cmd_in),
    .data_in  (req2_data_in),
    .out_data (out_data2),
    .out_resp (out_resp2)
  );

  calc1_port u_port3 (
    .c_clk    (c_clk),
    .reset    (reset),
    .cmd_in   (req3_cmd_in),
    .data_in  (req3_data_in),
    .out_data (out_data3),
    .out_resp (out_resp3)
  );

  calc1_port u_port4 (
    .c_clk    (c_clk),
    .reset    (reset),
    .cmd_in   (req4_cmd_in),
    .data_in  (req4_data_in),
    .out_data (out_data4),
    .out_resp (out_resp4)
  );

endmodule

// File: tb/tb_calc1_reference_model.sv
// Scoreboard bench for calc1_reference_model: every port is compared against an expected value every cycle.
module tb_calc1_reference_model;
  import calc1_pkg::*;

  typedef struct {
    int          port;
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        c_clk;
  logic        rst_n;
  logic [0:3]  cmd_drv  [1:4];
  logic [0:31] data_drv [1:4];
  logic [0:31] out_data [1:4];
  logic [0:1]  out_resp [1:4];

  int   cyc;
  int   vectors;
  int   miscompares;
  bit   mon_en;
  exp_t sb[$];

  calc1_reference_model dut (
    .c_clk        (c_clk),
    .reset        (rst_n),
    .req1_cmd_in  (cmd_drv[1]),
    .req1_data_in (data_drv[1]),
    .req2_cmd_in  (cmd_drv[2]),
    .req2_data_in (data_drv[2]),
    .req3_cmd_in  (cmd_drv[3]),
    .req3_data_in (data_drv[3]),
    .req4_cmd_in  (cmd_drv[4]),
    .req4_data_in (data_drv[4]),
    .out_data1    (out_data[1]),
    .out_resp1    (out_resp[1]),
    .out_data2    (out_data[2]),
    .out_resp2    (out_resp[2]),
    .out_data3    (out_data[3]),
    .out_resp3    (out_resp[3]),
    .out_data4    (out_data[4]),
    .out_resp4    (out_resp[4])
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  always @(posedge c_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Unsigned 32-bit golden arithmetic, written independently of the DUT's structure
  function automatic exp_t model(input int port, input logic [3:0] cmd,
                                 input logic [31:0] a, input logic [31:0] b, input int when);
    exp_t e;
    e.port = port;
    e.cyc  = when;
    e.resp = 2'd2;
    e.data = 32'd0;
    case (cmd)
      4'd1: if (a <= 32'hFFFF_FFFF - b) begin e.resp = 2'd1; e.data = a + b; end
      4'd2: if (b <= a) begin e.resp = 2'd1; e.data = a - b; end
      4'd5: begin e.resp = 2'd1; e.data = a << b[4:0]; end
      4'd6: begin e.resp = 2'd1; e.data = a >> b[4:0]; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic [3:0] cmd,
                               input logic [31:0] op1, input logic [31:0] op2);
    sb.push_back(model(port, cmd, op1, op2, cyc + 3));
    cmd_drv[port]  = cmd;
    data_drv[port] = op1;
    step();
    cmd_drv[port]  = 4'd0;
    data_drv[port] = op2;
    step();
    data_drv[port] = 32'd0;
  endtask

  task automatic randomBurst(input int port);
    logic [3:0]  c;
    logic [31:0] a, b;
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 4))
        0: c = 4'd1;
        1: c = 4'd2;
        2: c = 4'd5;
        3: c = 4'd6;
        default: c = 4'($urandom_range(1, 15));
      endcase
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      applyStimulus(port, c, a, b);
    end
  endtask

  // Any port without a scheduled response this cycle must read 0/0
  always @(negedge c_clk) begin
    if (mon_en) begin
      for (int p = 1; p <= 4; p++) begin
        exp_t e;
        int   idx;
        e.port = p;
        e.cyc  = cyc;
        e.resp = 2'd0;
        e.data = 32'd0;
        idx    = -1;
        foreach (sb[i]) if (sb[i].port == p && sb[i].cyc == cyc) idx = i;
        if (idx >= 0) begin
          e = sb[idx];
          sb.delete(idx);
        end
        checkOutput($sformatf("p%0d_resp_c%0d", p, cyc), 32'(out_resp[p]), 32'(e.resp));
        checkOutput($sformatf("p%0d_data_c%0d", p, cyc), 32'(out_data[p]), e.data);
      end
    end
  end

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    rst_n       = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      cmd_drv[p]  = 4'd0;
      data_drv[p] = 32'd0;
    end

    repeat (3) @(posedge c_clk);
    @(negedge c_clk);
    for (int p = 1; p <= 4; p++) begin
      checkOutput($sformatf("reset_p%0d_resp", p), 32'(out_resp[p]), 32'd0);
      checkOutput($sformatf("reset_p%0d_data", p), 32'(out_data[p]), 32'd0);
    end
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    applyStimulus(1, CMD_ADD, 32'd255, 32'd1);
    step();
    applyStimulus(2, CMD_ADD, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(3, CMD_SUB, 32'd5, 32'd6);
    applyStimulus(3, CMD_SUB, 32'd6, 32'd6);
    applyStimulus(4, CMD_LSH, 32'h0000_0001, 32'h0000_0023);
    applyStimulus(4, CMD_RSH, 32'h8000_0000, 32'd31);
    step();

    fork
      applyStimulus(1, 4'd3,  32'd10, 32'd20);
      applyStimulus(2, 4'd4,  32'd10, 32'd20);
      applyStimulus(3, 4'd7,  32'd10, 32'd20);
      applyStimulus(4, 4'd15, 32'd10, 32'd20);
    join
    step();

    applyStimulus(1, CMD_ADD, 32'd1, 32'd1);
    applyStimulus(1, CMD_ADD, 32'd2, 32'd2);
    repeat (3) step();

    fork
      randomBurst(1);
      randomBurst(2);
      randomBurst(3);
      randomBurst(4);
    join
    repeat (4) step();

    // Port2 response is live when reset drops mid-flight of a port1 ADD
    fork
      applyStimulus(2, CMD_ADD, 32'd3, 32'd4);
      begin
        step();
        cmd_drv[1]  = CMD_ADD;
        data_drv[1] = 32'd10;
        step();
        cmd_drv[1]  = 4'd0;
        data_drv[1] = 32'd20;
        step();
        data_drv[1] = 32'd0;
      end
    join
    @(negedge c_clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_p2_resp", 32'(out_resp[2]), 32'd0);
    checkOutput("async_reset_p2_data", 32'(out_data[2]), 32'd0);
    repeat (2) @(negedge c_clk);
    #2;
    rst_n = 1'b1;
    repeat (6) step();

    checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
